// File: rtl/player_sprite_ctrl.sv
// player_sprite_ctrl
//   Player sprite controller. Moves a sprite one pixel per prescaler period
//   inside a programmable play area. Button conflicts are resolved by
//   priority L > R > U > D. Plus-shaped blasts are checked against the
//   sprite box. A lives counter with post-hit invulnerability is kept, and
//   game over is sticky until reset.
//
//   Optional build macro RESPAWN_EN: a non-fatal hit also returns the sprite
//   to the spawn point and drops the FSM to IDLE in the same cycle.
//
//   Ports
//     clk, reset_n        clock, asynchronous active-low reset
//     L, R, U, D          direction buttons (level)
//     blocked[3:0]        {down,up,right,left} move inhibit
//     v_x, v_y            current VGA pixel
//     e_x, e_y            blast centre tile top-left
//     expl_pulse          one-cycle blast strobe
//     pos_x, pos_y        sprite top-left
//     facing              last latched direction (00 L, 01 R, 10 U, 11 D)
//     moving              FSM is in MOVE
//     lives, invuln       remaining lives, invulnerability window active
//     game_over           sticky, lives exhausted
//     sprite_on           v_x/v_y inside the sprite box (combinational)
//     spr_row, spr_col    pixel offset inside the sprite, for the ROM
//
//   state | meaning
//   IDLE  | no button held, sprite at rest
//   MOVE  | a direction is latched, prescaler running, steps at terminal count
//   DEAD  | lives exhausted, absorbing until reset
module player_sprite_ctrl #(
    parameter int CW          = 10,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int TILE        = 16,
    parameter int MIN_X       = 143,
    parameter int MAX_X       = 784,
    parameter int MIN_Y       = 34,
    parameter int MAX_Y       = 516,
    parameter int SPAWN_X     = 143,
    parameter int SPAWN_Y     = 34,
    parameter int STEP_DIV    = 1400000,
    parameter int BLAST_RANGE = 3,
    parameter int LIVES       = 3,
    parameter int INVULN_CYC  = 50000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          L,
    input  logic          R,
    input  logic          U,
    input  logic          D,
    input  logic [3:0]    blocked,
    input  logic [CW-1:0] v_x,
    input  logic [CW-1:0] v_y,
    input  logic [CW-1:0] e_x,
    input  logic [CW-1:0] e_y,
    input  logic          expl_pulse,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic [1:0]    facing,
    output logic          moving,
    output logic [3:0]    lives,
    output logic          invuln,
    output logic          game_over,
    output logic          sprite_on,
    output logic [CW-1:0] spr_row,
    output logic [CW-1:0] spr_col
);

    localparam int PW  = $clog2(STEP_DIV);
    localparam int IW  = $clog2(INVULN_CYC + 1);
    localparam int SW  = CW + 2;
    localparam int CW1 = CW + 1;

    localparam logic [PW-1:0] PRESC_TC = PW'(STEP_DIV - 1);
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_CYC);
    localparam logic [CW-1:0] X_LO     = CW'(MIN_X);
    localparam logic [CW-1:0] X_HI     = CW'(MAX_X - SPR_W);
    localparam logic [CW-1:0] Y_LO     = CW'(MIN_Y);
    localparam logic [CW-1:0] Y_HI     = CW'(MAX_Y - SPR_H);
    localparam logic [CW-1:0] SPAWN_XC = CW'(SPAWN_X);
    localparam logic [CW-1:0] SPAWN_YC = CW'(SPAWN_Y);

    localparam logic signed [SW-1:0] ARM_S  = SW'(BLAST_RANGE * TILE);
    localparam logic signed [SW-1:0] TILE_S = SW'(TILE);
    localparam logic signed [SW-1:0] SPRW_S = SW'(SPR_W);
    localparam logic signed [SW-1:0] SPRH_S = SW'(SPR_H);
    localparam logic [CW1-1:0]       SPRW_U = CW1'(SPR_W);
    localparam logic [CW1-1:0]       SPRH_U = CW1'(SPR_H);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] pos_x_q,   pos_x_d;
    logic [CW-1:0] pos_y_q,   pos_y_d;
    logic [1:0]    facing_q,  facing_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [3:0]    lives_q,   lives_d;
    logic [IW-1:0] inv_cnt_q, inv_cnt_d;
    logic [3:0]    btn_prev_q, btn_prev_d;

    logic [3:0] btn;
    logic       any_btn;
    logic       new_press;
    logic [1:0] prio_dir;
    logic       can_step;
    logic       h_hit, v_hit, hit_take;

    logic signed [SW-1:0] px, py, ex, ey;

    assign btn       = {D, U, R, L};
    assign any_btn   = |btn;
    assign new_press = |(btn & ~btn_prev_q);
    assign prio_dir  = L ? 2'b00 : R ? 2'b01 : U ? 2'b10 : 2'b11;

    // Widened signed copies so the beam edges can go below zero or past
    // the coordinate range without wrapping.
    assign px = $signed({2'b00, pos_x_q});
    assign py = $signed({2'b00, pos_y_q});
    assign ex = $signed({2'b00, e_x});
    assign ey = $signed({2'b00, e_y});

    // Half-open overlap: boxes that only touch along an edge do not hit.
    assign h_hit = (px < ex + TILE_S + ARM_S) && (px + SPRW_S > ex - ARM_S) &&
                   (py < ey + TILE_S)         && (py + SPRH_S > ey);
    assign v_hit = (px < ex + TILE_S)         && (px + SPRW_S > ex) &&
                   (py < ey + TILE_S + ARM_S) && (py + SPRH_S > ey - ARM_S);
    assign hit_take = expl_pulse && (state_q != S_DEAD) && (inv_cnt_q == '0) &&
                      (h_hit || v_hit);

    always_comb begin
        can_step = 1'b0;
        case (facing_q)
            2'b00:   can_step = pos_x_q > X_LO;
            2'b01:   can_step = pos_x_q < X_HI;
            2'b10:   can_step = pos_y_q > Y_LO;
            default: can_step = pos_y_q < Y_HI;
        endcase
        if (blocked[facing_q]) can_step = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        facing_d   = facing_q;
        presc_d    = presc_q;
        lives_d    = lives_q;
        inv_cnt_d  = inv_cnt_q;
        btn_prev_d = btn;

        if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - IW'(1);

        case (state_q)
            S_IDLE: begin
                if (any_btn) begin
                    state_d  = S_MOVE;
                    facing_d = prio_dir;
                    presc_d  = '0;
                end
            end
            S_MOVE: begin
                if (!any_btn) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (prio_dir != facing_q || new_press) begin
                    // Re-latching restarts the step cadence from zero.
                    facing_d = prio_dir;
                    presc_d  = '0;
                end else if (presc_q == PRESC_TC) begin
                    presc_d = '0;
                    if (can_step) begin
                        case (facing_q)
                            2'b00:   pos_x_d = pos_x_q - CW'(1);
                            2'b01:   pos_x_d = pos_x_q + CW'(1);
                            2'b10:   pos_y_d = pos_y_q - CW'(1);
                            default: pos_y_d = pos_y_q + CW'(1);
                        endcase
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase

        // The hit test above used the pre-update position; a step computed
        // this cycle still commits unless a respawn overrides it.
        if (hit_take) begin
            lives_d   = lives_q - 4'd1;
            inv_cnt_d = INV_LOAD;
            if (lives_q == 4'd1) begin
                state_d = S_DEAD;
            end
`ifdef RESPAWN_EN
            else begin
                state_d = S_IDLE;
                pos_x_d = SPAWN_XC;
                pos_y_d = SPAWN_YC;
                presc_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pos_x_q    <= SPAWN_XC;
            pos_y_q    <= SPAWN_YC;
            facing_q   <= 2'b11;
            presc_q    <= '0;
            lives_q    <= 4'(LIVES);
            inv_cnt_q  <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            facing_q   <= facing_d;
            presc_q    <= presc_d;
            lives_q    <= lives_d;
            inv_cnt_q  <= inv_cnt_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign facing    = facing_q;
    assign moving    = (state_q == S_MOVE);
    assign game_over = (state_q == S_DEAD);
    assign lives     = lives_q;
    assign invuln    = (inv_cnt_q != '0);

    assign sprite_on = ({1'b0, v_x} >= {1'b0, pos_x_q}) &&
                       ({1'b0, v_x} <  {1'b0, pos_x_q} + SPRW_U) &&
                       ({1'b0, v_y} >= {1'b0, pos_y_q}) &&
                       ({1'b0, v_y} <  {1'b0, pos_y_q} + SPRH_U);
    assign spr_row   = v_y - pos_y_q;
    assign spr_col   = v_x - pos_x_q;

endmodule
